lsu_subword: RTL

- Load/store unit that sits directly upstream of the word-only data memory. The data memory offers 32-bit word access only, with combinational read and a clocked write enable.
- Converts core requests for byte, halfword and word loads and stores into word transactions.
- Byte and halfword stores use a read-modify-write sequence.
- Loads are sign- or zero-extended. Misaligned and illegal requests are reported to the core, and no memory access is made for them.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_subword_if.sv | 33 +++
 rtl/lsu_byte_lane.sv | 53 +++++
 rtl/lsu_subword.sv | 134 +++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the sub-word load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    // True for any request that must not touch memory: illegal size or misaligned address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_subword_if.sv
// Core-request and word-memory signals of the sub-word load/store unit.
interface lsu_subword_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic              mem_wrEn;
    logic [31:0]       mem_rd;

    // Environment side: the core issuing requests plus the word memory returning read data.
    modport master (
        output req, we, size, sign_ext, addr, wdata, mem_rd,
        input  busy, done, err, rdata, mem_addr, mem_wd, mem_wrEn
    );

    // The load/store unit itself.
    modport slave (
        input  req, we, size, sign_ext, addr, wdata, mem_rd,
        output busy, done, err, rdata, mem_addr, mem_wd, mem_wrEn
    );

endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts/extends a loaded sub-word and merges a stored one.
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int unsigned BIG_ENDIAN = 0
) (
    input  logic [31:0] mem_word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ext_o,
    output logic [31:0] merge_o
);

    logic [1:0]  byte_sel;
    logic        half_sel;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Map the byte address onto a physical bit position; big-endian mirrors the lane order.
    always_comb begin
        byte_sel = (BIG_ENDIAN != 0) ? ~addr_lo_i : addr_lo_i;
        half_sel = (BIG_ENDIAN != 0) ? ~addr_lo_i[1] : addr_lo_i[1];
        byte_sh  = {byte_sel, 3'b000};
        half_sh  = {half_sel, 4'b0000};
        byte_val = 8'(mem_word_i >> byte_sh);
        half_val = 16'(mem_word_i >> half_sh);
    end

    // Load path: pick the lane and extend to 32 bits.
    always_comb begin
        case (size_i)
            SZ_BYTE: ext_o = {{24{sign_ext_i & byte_val[7]}}, byte_val};
            SZ_HALF: ext_o = {{16{sign_ext_i & half_val[15]}}, half_val};
            default: ext_o = mem_word_i;
        endcase
    end

    // Store path: replace only the target lane, keep every other bit of the old word.
    always_comb begin
        case (size_i)
            SZ_BYTE: merge_o = (mem_word_i & ~(32'h0000_00FF << byte_sh))
                             | ({24'b0, wdata_i[7:0]} << byte_sh);
            SZ_HALF: merge_o = (mem_word_i & ~(32'h0000_FFFF << half_sh))
                             | ({16'b0, wdata_i[15:0]} << half_sh);
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_subword.sv
// Load/store unit turning byte/half/word core requests into word-only memory accesses.
module lsu_subword
    import lsu_pkg::*;
#(
    parameter int unsigned BIG_ENDIAN = 0,
    parameter int unsigned ADDR_W     = 32
) (
    input logic          clk,
    input logic          rst,
    lsu_subword_if.slave bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              sign_ext_q, sign_ext_d;
    logic [31:0]       merge_q, merge_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       ext_val;
    logic [31:0]       merge_val;

    lsu_byte_lane #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_lane (
        .mem_word_i(bus.mem_rd),
        .addr_lo_i (addr_q[1:0]),
        .size_i    (size_q),
        .sign_ext_i(sign_ext_q),
        .wdata_i   (wdata_q),
        .ext_o     (ext_val),
        .merge_o   (merge_val)
    );

    // Next-state: accept in IDLE, read (load result or merge) in RD, write in WR.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        we_d       = we_q;
        sign_ext_d = sign_ext_q;
        merge_d    = merge_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    addr_d     = bus.addr;
                    wdata_d    = bus.wdata;
                    size_d     = bus.size;
                    we_d       = bus.we;
                    sign_ext_d = bus.sign_ext;
                    if (is_misaligned(bus.size, bus.addr[1:0])) begin
                        // Rejected requests complete immediately without leaving IDLE.
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else if (bus.we && (bus.size == SZ_WORD)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (we_q) begin
                    merge_d = merge_val;
                    state_d = ST_WR;
                end else begin
                    rdata_d = ext_val;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                rdata_d = 32'h0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            we_q       <= 1'b0;
            sign_ext_q <= 1'b0;
            merge_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            we_q       <= we_d;
            sign_ext_q <= sign_ext_d;
            merge_q    <= merge_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // Outputs decoded from state; memory bus is quiet outside its active state.
    always_comb begin
        bus.busy     = (state_q != ST_IDLE);
        bus.done     = done_q;
        bus.err      = err_q;
        bus.rdata    = rdata_q;
        bus.mem_wrEn = (state_q == ST_WR);
        bus.mem_wd   = 32'h0;
        bus.mem_addr = '0;
        if (state_q == ST_WR) begin
            bus.mem_wd = (size_q == SZ_WORD) ? wdata_q : merge_q;
        end
        if (state_q != ST_IDLE) begin
            bus.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        end
    end

endmodule
